// File: rtl/fft_bfly_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fft_bfly_seq_ctrl
//
// Sequencer for the 16-lane radix-2 butterfly of the 512-point FFT. It loads
// one frame of BLK blocks from the sample source into the working buffer.
// It then runs STAGES passes over the buffer. Each pass streams every block
// through the butterfly and writes the results back in place. The sequencer
// also supplies the stage index and the twiddle base address, and it pulses
// frame_done when the frame is complete.
//
// Optional feature (compile-time macro FFT_SEQ_CHK_EN):
//   defined   -> adds the sticky seq_err output. It flags butterfly results
//                that arrive outside a pass, or more results than reads.
//   undefined -> no seq_err port and no checking logic.
//
// Ports:
//   clk          clock
//   rstn         asynchronous reset, active-low
//   start        one-cycle frame start request (honoured in IDLE only)
//   abort        synchronous abort back to IDLE
//   in_valid     source presents one 16-sample block
//   in_ready     block accepted from the source (LOAD only)
//   rd_en        buffer read strobe (buffer has 1-cycle read latency)
//   rd_addr      buffer block read address
//   bf_valid_in  butterfly valid_in, rd_en delayed by one cycle
//   bf_valid_out butterfly result valid
//   wr_en        buffer write strobe
//   wr_sel       0 = write source data, 1 = write butterfly result
//   wr_addr      buffer block write address
//   stage        current pass index 0..STAGES-1
//   tw_base      twiddle base for the block currently entering the butterfly
//   busy         high in every state except IDLE
//   frame_done   one-cycle pulse at frame completion
//   seq_err      sticky sequencing error (FFT_SEQ_CHK_EN only)
// ---------------------------------------------------------------------------
module fft_bfly_seq_ctrl #(
  parameter int  NUM    = 16,
  parameter int  DATA   = 512,
  parameter int  STAGES = 9,
  localparam int BLK    = DATA / NUM,
  localparam int AW     = $clog2(BLK),
  localparam int TW     = $clog2(DATA / 2)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          bf_valid_in,
  input  logic          bf_valid_out,
  output logic          wr_en,
  output logic          wr_sel,
  output logic [AW-1:0] wr_addr,
  output logic [3:0]    stage,
  output logic [TW-1:0] tw_base,
  output logic          busy,
  output logic          frame_done
`ifdef FFT_SEQ_CHK_EN
  ,
  output logic          seq_err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam logic [AW-1:0] LAST_BLK   = AW'(BLK - 1);
  localparam logic [3:0]    LAST_STAGE = 4'(STAGES - 1);

  state_t        state;
  logic [AW-1:0] ld_cnt;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] wb_cnt;
  logic [AW-1:0] blkq;
  logic          pass_active;
  logic          load_fire;
  logic          wb_fire;

  // Simple status decodes of the state register. Abort suppresses any write
  // in its own cycle, so nothing lands in the buffer while we bail out.
  assign pass_active = (state == ISSUE) || (state == DRAIN);
  assign load_fire   = (state == LOAD) && in_valid && !abort;
  assign wb_fire     = pass_active && bf_valid_out && !abort;

  assign in_ready   = (state == LOAD);
  assign rd_en      = (state == ISSUE);
  assign rd_addr    = rd_cnt;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  // The write port is shared by the load path and the write-back path.
  // The strobe must line up with the data that the source or butterfly
  // presents in this same cycle, so it is decoded directly here. The two
  // paths never overlap because they live in different states.
  assign wr_en   = load_fire || wb_fire;
  assign wr_sel  = wb_fire;
  assign wr_addr = wb_fire ? wb_cnt : ld_cnt;

  // Twiddle base = (block * NUM) << stage, modulo DATA/2. The TW-bit cast
  // provides the modulo for free.
  assign tw_base = TW'((32'(blkq) * NUM) << stage);

  // Main sequencer. Reads and write-backs are counted independently, so a
  // pass can overlap its tail reads with early results. The pass ends on
  // the last write-back, not on the last read. Each counter only returns
  // to zero through a state change.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      ld_cnt <= '0;
      rd_cnt <= '0;
      wb_cnt <= '0;
      stage  <= '0;
    end else if (abort) begin
      state  <= IDLE;
      ld_cnt <= '0;
      rd_cnt <= '0;
      wb_cnt <= '0;
      stage  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= LOAD;
            ld_cnt <= '0;
            stage  <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (ld_cnt == LAST_BLK) begin
              state  <= ISSUE;
              ld_cnt <= '0;
              rd_cnt <= '0;
              wb_cnt <= '0;
            end else begin
              ld_cnt <= ld_cnt + 1'b1;
            end
          end
        end
        ISSUE, DRAIN: begin
          if (state == ISSUE) begin
            if (rd_cnt == LAST_BLK) begin
              state <= DRAIN;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
          if (bf_valid_out) begin
            if (wb_cnt == LAST_BLK) begin
              rd_cnt <= '0;
              wb_cnt <= '0;
              if (stage == LAST_STAGE) begin
                state <= DONE;
              end else begin
                stage <= stage + 4'd1;
                state <= ISSUE;
              end
            end else begin
              wb_cnt <= wb_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The buffer returns data one cycle after the read, so the butterfly
  // valid and the block address used for the twiddle lookup are delayed
  // together. That keeps tw_base aligned with bf_valid_in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bf_valid_in <= 1'b0;
      blkq        <= '0;
    end else begin
      bf_valid_in <= rd_en;
      blkq        <= rd_cnt;
    end
  end

`ifdef FFT_SEQ_CHK_EN
  // Sticky sequencing checker. It sets on a result outside a pass, and on
  // a result that would outnumber the reads issued so far in the pass.
  // Only reset or an accepted start clears it, and a set wins over a clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seq_err <= 1'b0;
    end else begin
      if ((state == IDLE) && start && !abort) begin
        seq_err <= 1'b0;
      end
      if (bf_valid_out && !pass_active) begin
        seq_err <= 1'b1;
      end
      if (bf_valid_out && (state == ISSUE) && (wb_cnt >= rd_cnt)) begin
        seq_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_bfly_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_bfly_seq_ctrl
//
// Self-checking bench for fft_bfly_seq_ctrl. A butterfly model with a
// configurable latency drives bf_valid_out. A negedge monitor logs every
// buffer write, read and twiddle value. After each frame the logs are
// compared with the sequence the frame should produce, derived from plain
// arithmetic on block/stage indices.
// ---------------------------------------------------------------------------
module tb_fft_bfly_seq_ctrl;

  localparam int NUM    = 16;
  localparam int DATA   = 512;
  localparam int STAGES = 9;
  localparam int BLK    = DATA / NUM;
  localparam int HALF   = DATA / 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic       bf_valid_in;
  logic       bf_valid_out;
  logic       wr_en;
  logic       wr_sel;
  logic [4:0] wr_addr;
  logic [3:0] stage;
  logic [7:0] tw_base;
  logic       busy;
  logic       frame_done;
`ifdef FFT_SEQ_CHK_EN
  logic       seq_err;
`endif

  int checks = 0;
  int errors = 0;

  int         bfLat = 2;
  logic       bfInject = 1'b0;
  logic [7:0] bfPipe;

  // Monitor logs, only ever appended to by the monitor
  int loadQ[$];
  int wbQ[$];
  int rdQ[$];
  int twQ[$];
  int doneCnt = 0;
  int busyCnt = 0;

  fft_bfly_seq_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .bf_valid_in  (bf_valid_in),
    .bf_valid_out (bf_valid_out),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_addr      (wr_addr),
    .stage        (stage),
    .tw_base      (tw_base),
    .busy         (busy),
    .frame_done   (frame_done)
`ifdef FFT_SEQ_CHK_EN
    ,
    .seq_err      (seq_err)
`endif
  );

  always #5 clk = ~clk;

  // Butterfly model: a result appears bfLat cycles after valid_in.
  // bfInject forces stray results.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) bfPipe <= '0;
    else       bfPipe <= {bfPipe[6:0], bf_valid_in};
  end
  assign bf_valid_out = bfPipe[bfLat-1] | bfInject;

  // Transaction monitor, sampled mid-cycle. Entries pack stage*256 + value.
  always @(negedge clk) begin
    if (rstn) begin
      if (wr_en && !wr_sel) loadQ.push_back(int'(wr_addr));
      if (wr_en && wr_sel)  wbQ.push_back(int'(stage) * 256 + int'(wr_addr));
      if (rd_en)            rdQ.push_back(int'(stage) * 256 + int'(rd_addr));
      if (bf_valid_in)      twQ.push_back(int'(stage) * 256 + int'(tw_base));
      if (frame_done)       doneCnt = doneCnt + 1;
      if (busy)             busyCnt = busyCnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic iv);
    @(posedge clk);
    #1;
    start    = st;
    abort    = ab;
    in_valid = iv;
  endtask

  // Runs one frame and checks every logged transaction against the
  // expected order: load 0..31, then for each stage s reads/write-backs of
  // blocks 0..31 and twiddle ((k*NUM) << s) mod DATA/2.
  task automatic runFrame(input int lat, input bit randValid, input bit startGlitch);
    int ldBase, wbBase, rdBase, twBase, doneBase, busyBase;
    int acc, loadCycles, n, s, k, expTw;
    bit finished;
    logic v, st;
    bfLat    = lat;
    ldBase   = loadQ.size();
    wbBase   = wbQ.size();
    rdBase   = rdQ.size();
    twBase   = twQ.size();
    doneBase = doneCnt;
    busyBase = busyCnt;
    applyStimulus(1'b1, 1'b0, 1'b1);
    acc = 0;
    loadCycles = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      v  = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
      st = startGlitch && ($urandom_range(0, 7) == 0);
      applyStimulus(st, 1'b0, v);
      if (acc < BLK) begin
        loadCycles++;
        if (v) acc++;
      end
      @(negedge clk);
      #1;
      if (doneCnt > doneBase) finished = 1'b1;
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("busy_after_done", busy, 0);
    checkOutput("frame_done_count", doneCnt - doneBase, 1);
    checkOutput("busy_cycles", busyCnt - busyBase, loadCycles + STAGES * (BLK + 1 + lat) + 1);

    n = loadQ.size() - ldBase;
    checkOutput("load_write_count", n, BLK);
    for (int i = 0; i < n && i < BLK; i++)
      checkOutput($sformatf("load_addr[%0d]", i), loadQ[ldBase + i], i);

    n = rdQ.size() - rdBase;
    checkOutput("read_count", n, STAGES * BLK);
    for (int i = 0; i < n && i < STAGES * BLK; i++)
      checkOutput($sformatf("read[%0d]", i), rdQ[rdBase + i], (i / BLK) * 256 + (i % BLK));

    n = wbQ.size() - wbBase;
    checkOutput("writeback_count", n, STAGES * BLK);
    for (int i = 0; i < n && i < STAGES * BLK; i++)
      checkOutput($sformatf("writeback[%0d]", i), wbQ[wbBase + i], (i / BLK) * 256 + (i % BLK));

    n = twQ.size() - twBase;
    checkOutput("twiddle_count", n, STAGES * BLK);
    for (int i = 0; i < n && i < STAGES * BLK; i++) begin
      s = i / BLK;
      k = i % BLK;
      expTw = ((k * NUM) << s) % HALF;
      checkOutput($sformatf("twiddle[s%0d,b%0d]", s, k), twQ[twBase + i], s * 256 + expTw);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ldBase, wbAtAbort, doneBase;
    bit found;

    // Reset state
    #1 rstn = 1'b0;
    #1;
    checkOutput("reset_outputs",
                {3'b0, in_ready, rd_en, bf_valid_in, wr_en, wr_sel, busy, frame_done,
                 rd_addr, wr_addr, stage, tw_base}, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset in the middle of LOAD, after 10 accepted blocks
    ldBase = loadQ.size();
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("midload_in_ready", in_ready, 1);
    checkOutput("midload_writes", loadQ.size() - ldBase, 10);
    #1 rstn = 1'b0;
    #1;
    checkOutput("midload_reset_outputs",
                {3'b0, in_ready, rd_en, bf_valid_in, wr_en, wr_sel, busy, frame_done,
                 rd_addr, wr_addr, stage, tw_base}, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rstn = 1'b1;

    // Full frame, in_valid held high, butterfly latency 2
    $display("[TB] full frame, latency 2");
    runFrame(2, 1'b0, 1'b0);

    // in_valid toggling during LOAD, stray start requests while busy
    $display("[TB] random in_valid frame with ignored starts");
    runFrame(2, 1'b1, 1'b1);

    // Random latency frame
    $display("[TB] random latency frame");
    runFrame(int'($urandom_range(1, 4)), 1'b1, 1'b0);

    // Start and abort together in IDLE: abort wins
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("start_abort_busy", busy, 0);
    checkOutput("start_abort_in_ready", in_ready, 0);

    // Abort during the DRAIN of stage 4, with results still in flight
    $display("[TB] abort in stage 4 drain");
    bfLat = 4;
    doneBase = doneCnt;
    applyStimulus(1'b1, 1'b0, 1'b1);
    found = 1'b0;
    for (int cyc = 0; cyc < 3000 && !found; cyc++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      if (stage == 4'd4 && busy && !rd_en && bf_valid_in == 1'b0) found = 1'b1;
    end
    checkOutput("abort_reached_drain", found, 1);
    wbAtAbort = wbQ.size();
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_stage", stage, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      bfInject = (i == 3);
    end
    bfInject = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("abort_no_late_writes", wbQ.size() - wbAtAbort, 0);
    checkOutput("abort_no_frame_done", doneCnt - doneBase, 0);

`ifdef FFT_SEQ_CHK_EN
    // Stray result in IDLE sets the sticky flag; a start clears it
    applyStimulus(1'b0, 1'b0, 1'b0);
    bfInject = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    bfInject = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("seq_err_set", seq_err, 1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("seq_err_held", seq_err, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("seq_err_cleared", seq_err, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
`endif

    // The controller must still run a clean frame after an abort
    $display("[TB] recovery frame after abort");
    runFrame(2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
